// File: rtl/jam_solver_param_if.sv
// Host-side bus of the assignment solver: solve request, cost-table read port and results.
interface jam_solver_param_if #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + $clog2(N);

  logic              START;
  logic [IW-1:0]     W;
  logic [IW-1:0]     J;
  logic [CW-1:0]     Cost;
  logic [SW-1:0]     MinCost;
  logic [MCW-1:0]    MatchCount;
  logic [N*IW-1:0]   BestPerm;
  logic              Valid;
  logic              Busy;

  modport master (
    output START, Cost,
    input  W, J, MinCost, MatchCount, BestPerm, Valid, Busy
  );

  modport slave (
    input  START, Cost,
    output W, J, MinCost, MatchCount, BestPerm, Valid, Busy
  );
endinterface

// File: rtl/jam_solver_param.sv
// Exhaustive assignment solver: loads an N x N cost table, then walks all N!
// permutations in lexicographic order, one per cycle, keeping the minimum
// total cost, how many permutations reach it and the first one that did.
module jam_solver_param #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16
) (
  input logic          CLK,
  input logic          RST,
  jam_solver_param_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   w;
  logic [IW-1:0]   j;
  logic [CW-1:0]   tbl [N][N];
  logic [IW-1:0]   perm [N];
  logic [SW-1:0]   min_cost;
  logic [MCW-1:0]  match_cnt;
  logic [N*IW-1:0] best_perm;
  logic            valid;
  logic            busy;

  logic            has_piv;
  logic [IW-1:0]   piv;
  logic [IW-1:0]   swp_idx;
  logic [IW-1:0]   swp [N];
  logic [IW-1:0]   nxt [N];
  logic [SW-1:0]   total;

  function automatic logic [MCW-1:0] sat_inc(input logic [MCW-1:0] v);
    return (v == {MCW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [N*IW-1:0] pack_perm(input logic [IW-1:0] p [N]);
    logic [N*IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = p[i];
    return r;
  endfunction

  function automatic logic [N*IW-1:0] ident_perm();
    logic [N*IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = IW'(i);
    return r;
  endfunction

  // Cost of the current permutation and its lexicographic successor.
  always_comb begin
    total   = '0;
    has_piv = 1'b0;
    piv     = '0;
    swp_idx = '0;
    for (int i = 0; i < N; i++) total = total + SW'(tbl[i][perm[i]]);
    for (int p = 0; p < N - 1; p++) begin
      if (perm[p] < perm[p+1]) begin
        piv     = IW'(p);
        has_piv = 1'b1;
      end
    end
    for (int q = 0; q < N; q++) begin
      if (q > int'(piv) && perm[q] > perm[piv]) swp_idx = IW'(q);
    end
    swp          = perm;
    swp[piv]     = perm[swp_idx];
    swp[swp_idx] = perm[piv];
    nxt          = swp;
    for (int i = 0; i < N; i++) begin
      if (i > int'(piv)) nxt[i] = swp[IW'(N + int'(piv) - i)];
    end
  end

  // Cost table capture; never reset because LOAD rewrites every entry.
  always_ff @(posedge CLK) begin
    if (state == LOAD) tbl[w][j] <= bus.Cost;
  end

  // Control FSM with registered outputs and result accumulation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      w         <= '0;
      j         <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      min_cost  <= '1;
      match_cnt <= '0;
      best_perm <= ident_perm();
      for (int i = 0; i < N; i++) perm[i] <= IW'(i);
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.START) begin
            state     <= LOAD;
            w         <= '0;
            j         <= '0;
            valid     <= 1'b0;
            busy      <= 1'b1;
            min_cost  <= '1;
            match_cnt <= '0;
          end else if (state == DONE) begin
            valid <= 1'b1;
          end
        end
        LOAD: begin
          if (j == IW'(N - 1)) begin
            j <= '0;
            if (w == IW'(N - 1)) begin
              w     <= '0;
              state <= EVAL;
              for (int i = 0; i < N; i++) perm[i] <= IW'(i);
            end else begin
              w <= w + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        EVAL: begin
          if (total < min_cost) begin
            min_cost  <= total;
            match_cnt <= MCW'(1);
            best_perm <= pack_perm(perm);
          end else if (total == min_cost) begin
            match_cnt <= sat_inc(match_cnt);
          end
          if (has_piv) begin
            perm <= nxt;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.W          = w;
  assign bus.J          = j;
  assign bus.MinCost    = min_cost;
  assign bus.MatchCount = match_cnt;
  assign bus.BestPerm   = best_perm;
  assign bus.Valid      = valid;
  assign bus.Busy       = busy;
endmodule

// File: tb/tb_jam_solver_param.sv
// Bench for jam_solver_param: four instances (N=8, N=8 with narrow count,
// N=4, N=3) run concurrently; results are scoreboarded against a
// brute-force enumeration model.
`timescale 1ns/1ps
module tb_jam_solver_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic rst_a, rst4;
  logic st0, st1, st2, st3;
  logic [6:0] c8 [8][8];
  logic [6:0] c4 [4][4];
  logic [6:0] c3 [4][4];

  jam_solver_param_if #(.N(8), .CW(7), .MCW(16)) if0 ();
  jam_solver_param_if #(.N(8), .CW(7), .MCW(8))  if1 ();
  jam_solver_param_if #(.N(4), .CW(7), .MCW(16)) if2 ();
  jam_solver_param_if #(.N(3), .CW(7), .MCW(16)) if3 ();

  jam_solver_param #(.N(8), .CW(7), .MCW(16)) u0 (.CLK(clk), .RST(rst_a), .bus(if0));
  jam_solver_param #(.N(8), .CW(7), .MCW(8))  u1 (.CLK(clk), .RST(rst_a), .bus(if1));
  jam_solver_param #(.N(4), .CW(7), .MCW(16)) u2 (.CLK(clk), .RST(rst4),  .bus(if2));
  jam_solver_param #(.N(3), .CW(7), .MCW(16)) u3 (.CLK(clk), .RST(rst_a), .bus(if3));

  assign if0.START = st0;
  assign if1.START = st1;
  assign if2.START = st2;
  assign if3.START = st3;
  assign if0.Cost  = c8[if0.W][if0.J];
  assign if1.Cost  = '0;
  assign if2.Cost  = c4[if2.W][if2.J];
  assign if3.Cost  = c3[if3.W][if3.J];

  logic        vld [4];
  logic        bsy [4];
  logic [31:0] mn_a [4];
  logic [31:0] cnt_a [4];
  logic [23:0] best_a [4];

  always_comb begin
    vld[0] = if0.Valid;  vld[1] = if1.Valid;  vld[2] = if2.Valid;  vld[3] = if3.Valid;
    bsy[0] = if0.Busy;   bsy[1] = if1.Busy;   bsy[2] = if2.Busy;   bsy[3] = if3.Busy;
    mn_a[0] = 32'(if0.MinCost);  mn_a[1] = 32'(if1.MinCost);
    mn_a[2] = 32'(if2.MinCost);  mn_a[3] = 32'(if3.MinCost);
    cnt_a[0] = 32'(if0.MatchCount);  cnt_a[1] = 32'(if1.MatchCount);
    cnt_a[2] = 32'(if2.MatchCount);  cnt_a[3] = 32'(if3.MatchCount);
    best_a[0] = 24'(if0.BestPerm);  best_a[1] = 24'(if1.BestPerm);
    best_a[2] = 24'(if2.BestPerm);  best_a[3] = 24'(if3.BestPerm);
  end

  typedef struct {
    int          mn;
    int          cnt;
    logic [23:0] best;
    int          lat;
    int          t0;
  } exp_t;

  exp_t exp_q [4][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask

  // All permutations enumerated as base-n numbers (digit 0 most significant),
  // so the first strict minimum met is the lexicographically first one.
  function automatic void model(input int n, input int mcw, input int c [8][8], output exp_t e);
    int d [8];
    int tmp, sum, mask, ok, total, iw, fact;
    iw = (n <= 2) ? 1 : ((n <= 4) ? 2 : 3);
    total = 1;
    for (int i = 0; i < n; i++) total = total * n;
    e.mn = 32'h7fffffff; e.cnt = 0; e.best = '0; e.t0 = 0;
    for (int code = 0; code < total; code++) begin
      tmp = code; mask = 0; ok = 1;
      for (int i = n - 1; i >= 0; i--) begin d[i] = tmp % n; tmp = tmp / n; end
      for (int i = 0; i < n; i++) begin
        if (mask[d[i]]) ok = 0;
        mask = mask | (1 << d[i]);
      end
      if (ok != 0) begin
        sum = 0;
        for (int i = 0; i < n; i++) sum = sum + c[i][d[i]];
        if (sum < e.mn) begin
          e.mn = sum; e.cnt = 1; e.best = '0;
          for (int i = 0; i < n; i++) e.best = e.best | (24'(d[i]) << (i * iw));
        end else if (sum == e.mn) begin
          e.cnt = e.cnt + 1;
        end
      end
    end
    if (e.cnt > (1 << mcw) - 1) e.cnt = (1 << mcw) - 1;
    fact = 1;
    for (int i = 2; i <= n; i++) fact = fact * i;
    e.lat = n * n + fact + 1;
  endfunction

  task automatic sb_check(input int id);
    exp_t e;
    if (exp_q[id].size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL sb_unexpected_valid[%0d]: got Valid=1, want no result pending", id);
    end else begin
      e = exp_q[id].pop_front();
      chk($sformatf("min_cost[%0d]", id),    64'(mn_a[id]),   64'(e.mn));
      chk($sformatf("match_count[%0d]", id), 64'(cnt_a[id]),  64'(e.cnt));
      chk($sformatf("best_perm[%0d]", id),   64'(best_a[id]), 64'(e.best));
      chk($sformatf("latency[%0d]", id),     64'(cyc - e.t0), 64'(e.lat));
    end
  endtask

  logic pv [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  // Monitor: score each rising Valid against the oldest pending expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] === 1'b1 && pv[i] !== 1'b1) sb_check(i);
      pv[i] <= vld[i];
    end
  end

  task automatic set_st(input int id, input logic v);
    case (id)
      0: st0 = v;
      1: st1 = v;
      2: st2 = v;
      default: st3 = v;
    endcase
  endtask

  task automatic issue(input int id, input exp_t e);
    @(negedge clk); set_st(id, 1'b1);
    @(posedge clk); #1; set_st(id, 1'b0);
    e.t0 = cyc;
    exp_q[id].push_back(e);
  endtask

  task automatic wait_valid(input int id, input int budget);
    int k;
    k = 0;
    while (vld[id] !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    if (vld[id] !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL wait_valid[%0d]: got no Valid within %0d cycles, want Valid", id, budget);
    end
  endtask

  task automatic reset_checks4(input string tag);
    chk({tag, "_valid"}, 64'(vld[2]),   64'(0));
    chk({tag, "_busy"},  64'(bsy[2]),   64'(0));
    chk({tag, "_min"},   64'(mn_a[2]),  64'(511));
    chk({tag, "_cnt"},   64'(cnt_a[2]), 64'(0));
    chk({tag, "_best"},  64'(best_a[2]), 64'(8'hE4));
    chk({tag, "_W"},     64'(if2.W),    64'(0));
    chk({tag, "_J"},     64'(if2.J),    64'(0));
  endtask

  task automatic run4(input int fixedv, input int maxv, input bit wj);
    int   t [8][8];
    exp_t e;
    for (int i = 0; i < 8; i++) for (int k = 0; k < 8; k++) t[i][k] = 0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        t[i][k]  = (fixedv >= 0) ? fixedv : int'($urandom_range(0, maxv));
        c4[i][k] = 7'(t[i][k]);
      end
    end
    model(4, 16, t, e);
    issue(2, e);
    chk("n4_valid_after_start", 64'(vld[2]), 64'(0));
    chk("n4_busy_after_start",  64'(bsy[2]), 64'(1));
    if (wj) begin
      for (int c = 0; c < 16; c++) begin
        chk("n4_load_W", 64'(if2.W), 64'(c / 4));
        chk("n4_load_J", 64'(if2.J), 64'(c % 4));
        st2 = (c == 5);
        @(posedge clk); #1;
      end
      st2 = 1'b0;
      chk("n4_eval_W",    64'(if2.W),  64'(0));
      chk("n4_eval_J",    64'(if2.J),  64'(0));
      chk("n4_eval_busy", 64'(bsy[2]), 64'(1));
      repeat (3) @(posedge clk);
      #1; st2 = 1'b1;
      @(posedge clk); #1; st2 = 1'b0;
    end
    wait_valid(2, 200);
  endtask

  task automatic seq0();
    exp_t e;
    chk("n8_reset_min",  64'(mn_a[0]),   64'(1023));
    chk("n8_reset_cnt",  64'(cnt_a[0]),  64'(0));
    chk("n8_reset_best", 64'(best_a[0]), 64'(24'o76543210));
    e.mn = 0; e.cnt = 1; e.best = 24'o76543210; e.lat = 64 + 40320 + 1; e.t0 = 0;
    issue(0, e);
    chk("n8_busy", 64'(bsy[0]), 64'(1));
    wait_valid(0, 41000);
  endtask

  task automatic seq1();
    exp_t e;
    e.mn = 0; e.cnt = 255; e.best = 24'o76543210; e.lat = 64 + 40320 + 1; e.t0 = 0;
    issue(1, e);
    chk("n8s_busy", 64'(bsy[1]), 64'(1));
    wait_valid(1, 41000);
  endtask

  task automatic seq2();
    int   t [8][8];
    exp_t e;
    reset_checks4("n4_por");
    run4(5, 0, 1'b1);
    for (int k = 0; k < 6; k++) run4(-1, (k % 2 == 0) ? 3 : 127, (k == 3));
    // Reset and start together while DONE: reset must win.
    @(negedge clk); rst4 = 1'b1; st2 = 1'b1;
    @(posedge clk); #1; rst4 = 1'b0; st2 = 1'b0;
    reset_checks4("n4_rst_start");
    @(posedge clk); #1;
    chk("n4_rst_start_idle_busy", 64'(bsy[2]), 64'(0));
    // Reset in the middle of EVAL, then a clean re-solve of the same table.
    for (int i = 0; i < 8; i++) for (int k = 0; k < 8; k++) t[i][k] = 0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        t[i][k]  = int'($urandom_range(0, 3));
        c4[i][k] = 7'(t[i][k]);
      end
    end
    model(4, 16, t, e);
    issue(2, e);
    repeat (26) @(posedge clk);
    #1;
    chk("n4_mid_eval_busy", 64'(bsy[2]), 64'(1));
    @(negedge clk); rst4 = 1'b1;
    @(posedge clk); #1; rst4 = 1'b0;
    exp_q[2].delete();
    reset_checks4("n4_mid_eval_rst");
    issue(2, e);
    wait_valid(2, 200);
  endtask

  task automatic seq3();
    int   t [8][8];
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) for (int k = 0; k < 8; k++) t[i][k] = 0;
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) begin
          t[i][k]  = (r == 0) ? ((i + k) % 3) * 10 + 1 : int'($urandom_range(0, 7));
          c3[i][k] = 7'(t[i][k]);
        end
      end
      model(3, 16, t, e);
      issue(3, e);
      chk("n3_busy", 64'(bsy[3]), 64'(1));
      wait_valid(3, 100);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst4 = 1'b1;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
    for (int i = 0; i < 8; i++) for (int k = 0; k < 8; k++) c8[i][k] = (i == k) ? 7'd0 : 7'd1;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) begin c4[i][k] = '0; c3[i][k] = '0; end
    repeat (3) @(posedge clk);
    #1; rst_a = 1'b0; rst4 = 1'b0;
    fork
      seq0();
      seq1();
      seq2();
      seq3();
    join
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("sb_drained[%0d]", i), 64'(exp_q[i].size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
